// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the first-word-fall-through FIFO.
package fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer with increment enable; wraps naturally at 2**WIDTH.
module fifo_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: head entry shown on dout with zero read latency,
// optional overwrite-oldest policy when written while full.
module fwft_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter bit OVERWRITE  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          wr,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count_q;
    fifo_state_e           state;
    logic                  do_wr;
    logic                  do_rd;

    always_comb begin
        state = FIFO_PARTIAL;
        if (count_q == '0) begin
            state = FIFO_EMPTY;
        end else if (count_q == DEPTH_C) begin
            state = FIFO_FULL;
        end
    end

    assign empty = (state == FIFO_EMPTY);
    assign full  = (state == FIFO_FULL);
    assign count = count_q;
    assign dout  = empty ? '0 : mem[rptr];

    // A write while full either evicts the head (overwrite) or is dropped,
    // unless a paired read frees the slot in the same edge.
    assign do_wr = !reset && wr && (!full || rd || OVERWRITE);
    assign do_rd = !reset && ((rd && !empty) || (wr && !rd && full && OVERWRITE));

    fifo_ptr #(.WIDTH(PW)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (do_wr),
        .ptr   (wptr)
    );

    fifo_ptr #(.WIDTH(PW)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (do_rd),
        .ptr   (rptr)
    );

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - 1'b1;
            end
            overflow  <= wr && !rd && full;
            underflow <= rd && empty;
        end
    end

endmodule
